memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning word-address width of both requesters and the memory port.
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port a_valid  input  1  port A (fetch) read request.
REQ-005 SHALL have port a_ready  output  1  port A request granted this cycle (combinational).
REQ-006 SHALL have port a_addr  input  ADDR_WIDTH  port A word address.
REQ-007 SHALL have port a_rvalid  output  1  rdata/rgrubby belong to port A (registered).
REQ-008 SHALL have port b_valid  input  1  port B (data) request.
REQ-009 SHALL have port b_ready  output  1  port B request granted this cycle (combinational).
REQ-010 SHALL have port b_write  input  1  port B request is a write.
REQ-011 SHALL have port b_wmask  input  4  port B byte enables.
REQ-012 SHALL have port b_wdata  input  32  port B write data.
REQ-013 SHALL have port b_wgrubby  input  1  port B grubby bit to store.
REQ-014 SHALL have port b_addr  input  ADDR_WIDTH  port B word address.
REQ-015 SHALL have port b_rvalid  output  1  rdata/rgrubby belong to port B, or write ack (registered).
REQ-016 SHALL have port rdata  output  32  shared read data, passthrough of mem_rdata.
REQ-017 SHALL have port rgrubby  output  1  shared grubby flag, passthrough of mem_rgrubby.
REQ-018 SHALL have ports mem_valid/mem_write (1), mem_wmask (4), mem_wdata (32), mem_wgrubby (1), mem_addr (ADDR_WIDTH)  output  to the single-ported 33-bit memory.
REQ-019 SHALL have ports mem_rdata (32), mem_rgrubby (1)  input  memory read result, valid one cycle after mem_valid.

Function
REQ-020 SHALL grant at most one port per cycle; a_ready and b_ready never both 1.
REQ-021 SHALL, with only one valid request, grant that port in the same cycle (zero added latency).
REQ-022 SHALL, with both valid, grant the port NOT granted most recently (round-robin); state bit last_grant updates on every grant.
REQ-023 SHALL drive mem_valid = a_ready | b_ready; mem_addr = granted port's address; mem_addr = a_addr when idle.
REQ-024 SHALL drive mem_write = b_ready & b_write, mem_wmask = b_wmask when mem_write else 4'b0000, mem_wdata/mem_wgrubby = b_wdata/b_wgrubby.
REQ-025 SHALL assert a_rvalid (resp. b_rvalid) exactly one cycle after a_ready (resp. b_ready), for one cycle per grant.
REQ-026 SHALL assert b_rvalid for writes as acknowledge; rdata then holds pre-write content and is don't-care to the requester.
REQ-027 SHALL support back-to-back grants to the same port every cycle (full throughput, no bubble).
REQ-028 SHALL require requesters to hold valid and request fields stable until ready; a request withdrawn before ready is discarded without memory access.
REQ-029 SHALL never starve: a port continuously valid is granted within 2 cycles.
REQ-030 SHALL treat b_valid & b_write with b_wmask = 0 as a normal grant (memory ignores data) and still ack.

Reset
REQ-031 SHALL, while rst = 1, force a_rvalid = b_rvalid = 0, a_ready = b_ready = mem_valid = mem_write = 0, last_grant = B (A wins first conflict after reset); a response in flight at reset is dropped.

Verification
REQ-032 A only: a_valid=1, a_addr=0x010 one cycle -> a_ready=1, mem_addr=0x010 same cycle; a_rvalid=1 next cycle, rdata = stored word.
REQ-033 Conflict after reset: a_valid=b_valid=1 for 4 cycles -> grants A,B,A,B; rvalids follow one cycle later each, never both high.
REQ-034 B write: b_write=1, b_wmask=4'b0011, b_wdata=0xDEADBEEF, b_addr=0x020 -> mem_write=1, mem_wmask=0011; b_rvalid next cycle; subsequent A read of 0x020 returns low half 0xBEEF, grubby 1.
REQ-035 A idle-read gating: a_valid=0, b_valid=0 -> mem_valid=0, mem_wmask=0, no rvalid.
REQ-036 Reset mid-operation: grant B read, assert rst in following cycle -> b_rvalid stays 0; after release, conflict grants A first.
REQ-037 Stream: b_valid=1 for 8 cycles, a_valid=0 -> 8 consecutive b_ready and 8 consecutive b_rvalid pulses, no gaps.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported 33-bit (32 data + grubby) memory.
// Port A is the fetch (read-only) requester, port B is the data requester (read/write).
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_rvalid,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_write,
    input  logic [3:0]            b_wmask,
    input  logic [31:0]           b_wdata,
    input  logic                  b_wgrubby,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_rvalid,

    output logic [31:0]           rdata,
    output logic                  rgrubby,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wgrubby,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rgrubby
);

    localparam int unsigned MASK_W = 4;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t last_grant;
    grant_t last_grant_next;
    logic   a_win;
    logic   b_win;

    // Grant selection: a lone requester wins at once; on conflict the port not served last wins.
    always_comb begin
        a_win           = 1'b0;
        b_win           = 1'b0;
        last_grant_next = last_grant;
        if (!rst) begin
            if (a_valid && b_valid) begin
                if (last_grant == GRANT_B) begin
                    a_win = 1'b1;
                end else begin
                    b_win = 1'b1;
                end
            end else begin
                a_win = a_valid;
                b_win = b_valid;
            end
            if (a_win) begin
                last_grant_next = GRANT_A;
            end else if (b_win) begin
                last_grant_next = GRANT_B;
            end
        end
    end

    // Arbitration state and response ownership; a read issued now returns data next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_B;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
        end else begin
            last_grant <= last_grant_next;
            a_rvalid   <= a_win;
            b_rvalid   <= b_win;
        end
    end

    assign a_ready     = a_win;
    assign b_ready     = b_win;

    assign mem_valid   = a_win | b_win;
    assign mem_addr    = b_win ? b_addr : a_addr;
    assign mem_write   = b_win & b_write;
    assign mem_wmask   = mem_write ? b_wmask : MASK_W'(0);
    assign mem_wdata   = b_wdata;
    assign mem_wgrubby = b_wgrubby;

    assign rdata       = mem_rdata;
    assign rgrubby     = mem_rgrubby;

endmodule
